// File: rtl/cut_sweep_ctrl.sv
// cut_sweep_ctrl: exhaustive input sweep of a combinational CUT with MISR compaction and golden compare.
// Define CUTSEQ_CMP_EN to add the per-vector exact compare (exp_in, err_cnt, first_fail_vec).
module cut_sweep_ctrl #(
    parameter int N_IN = 3,
    parameter int N_OUT = 10,
    parameter int SETTLE = 1,
    parameter logic [N_OUT-1:0] POLY = N_OUT'('h9)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N_OUT-1:0] golden_sig,
    input  logic [N_OUT-1:0] resp_in,
`ifdef CUTSEQ_CMP_EN
    input  logic [N_OUT-1:0] exp_in,
    output logic [N_IN:0]    err_cnt,
    output logic [N_IN-1:0]  first_fail_vec,
`endif
    output logic [N_IN-1:0]  vec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_OUT-1:0] sig
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [N_OUT-1:0] sig_q, sig_d, sig_nx;
    logic [7:0]       cnt_q, cnt_d;
    logic             pass_q, pass_d, ok_nx;
`ifdef CUTSEQ_CMP_EN
    logic [N_IN:0]    err_q, err_d, err_nx;
    logic [N_IN-1:0]  ffv_q, ffv_d;
    logic             mism;
`endif

    always_comb begin
        sig_nx = {sig_q[N_OUT-2:0], 1'b0} ^ (sig_q[N_OUT-1] ? POLY : '0) ^ resp_in;
`ifdef CUTSEQ_CMP_EN
        mism   = resp_in != exp_in;
        err_nx = (mism && !(&err_q)) ? err_q + 1'b1 : err_q;
        ok_nx  = (sig_nx == golden_sig) && (err_nx == '0);
        err_d  = err_q;
        ffv_d  = ffv_q;
`else
        ok_nx  = sig_nx == golden_sig;
`endif
        state_d = state_q;
        vec_d   = vec_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && !abort) begin
                    state_d = ST_SETTLE;
                    vec_d   = '0;
                    sig_d   = '0;
                    cnt_d   = 8'(SETTLE);
                    pass_d  = 1'b0;
`ifdef CUTSEQ_CMP_EN
                    err_d   = '0;
                    ffv_d   = '0;
`endif
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    vec_d   = '0;
                    pass_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    vec_d   = '0;
                    pass_d  = 1'b0;
                end else begin
                    sig_d = sig_nx;
`ifdef CUTSEQ_CMP_EN
                    err_d = err_nx;
                    if (mism && err_q == '0) ffv_d = vec_q;
`endif
                    // the all-ones vector is the last one; the counter never wraps
                    if (&vec_q) begin
                        state_d = ST_DONE;
                        pass_d  = ok_nx;
                    end else begin
                        state_d = ST_SETTLE;
                        vec_d   = vec_q + 1'b1;
                        cnt_d   = 8'(SETTLE);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            sig_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
`ifdef CUTSEQ_CMP_EN
            err_q   <= '0;
            ffv_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
`ifdef CUTSEQ_CMP_EN
            err_q   <= err_d;
            ffv_q   <= ffv_d;
`endif
        end
    end

    assign vec_out = vec_q;
    assign busy    = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
    assign done    = state_q == ST_DONE;
    assign pass    = pass_q;
    assign sig     = sig_q;
`ifdef CUTSEQ_CMP_EN
    assign err_cnt        = err_q;
    assign first_fail_vec = ffv_q;
`endif
endmodule

// File: tb/tb_cut_sweep_ctrl.sv
// tb_cut_sweep_ctrl: directed and randomized sweeps against a behavioural signature/timing model.
module tb_cut_sweep_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [9:0] golden_sig = '0;
    logic [9:0] resp_in, sig;
    logic [2:0] vec_out;
    logic       busy, done, pass;
    logic [9:0] tbl [8];
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;
    assign resp_in = tbl[vec_out];

`ifdef CUTSEQ_CMP_EN
    logic [9:0] exp_in;
    logic [3:0] err_cnt;
    logic [2:0] first_fail_vec;
    assign exp_in = tbl[vec_out];
`endif

    cut_sweep_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .golden_sig(golden_sig), .resp_in(resp_in),
`ifdef CUTSEQ_CMP_EN
        .exp_in(exp_in), .err_cnt(err_cnt), .first_fail_vec(first_fail_vec),
`endif
        .vec_out(vec_out), .busy(busy), .done(done), .pass(pass), .sig(sig)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // signature after the CUT responses for vectors 0..n-1 have been compacted
    function automatic logic [9:0] model(input int n);
        logic [10:0] s = '0;
        for (int v = 0; v < n; v++) begin
            s = s << 1;
            if (s[10]) s = s ^ 11'h409;
            s = s ^ {1'b0, tbl[v]};
        end
        return s[9:0];
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_vec"}, vec_out, 0);
    endtask

    task automatic sweep(input logic [9:0] gold, input int mid_start, input int abort_at, input int rst_at);
        golden_sig = gold;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("sig_cleared", sig, 0);
        for (int i = 0; i < 24; i++) begin
            chk("busy", busy, 1);
            chk("done_low", done, 0);
            chk("vec", vec_out, i / 3);
            if (i == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk_idle("abort");
                chk("abort_sig_hold", sig, model(i / 3));
                return;
            end
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                chk_idle("rst");
                chk("rst_sig", sig, 0);
                rst = 1'b0;
                return;
            end
            start = (i == mid_start);
            tick();
            start = 1'b0;
        end
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("sig", sig, model(8));
        chk("pass", pass, model(8) == gold);
        chk("vec_end", vec_out, 7);
        tick();
        tick();
        chk("done_hold", done, 1);
        chk("sig_hold", sig, model(8));
        chk("pass_hold", pass, model(8) == gold);
    endtask

    initial begin
        for (int v = 0; v < 8; v++) tbl[v] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        chk("reset_sig", sig, 0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 8; v++) tbl[v] = 10'h001;
        sweep(10'h0FF, -1, -1, -1);
        chk("const_sig", sig, 10'h0FF);
        sweep(10'h0FE, -1, -1, -1);

        for (int v = 0; v < 8; v++) tbl[v] = 10'(v);
        sweep(10'h00F, -1, -1, -1);
        chk("loop_sig", sig, 10'h00F);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_in_done", done, 1);

        sweep(10'h00F, -1, 15, -1);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_done", done, 0);

        sweep(10'h00F, -1, -1, 9);
        sweep(10'h00F, -1, -1, -1);
        sweep(10'h00F, 10, -1, -1);

        for (int r = 0; r < 12; r++) begin
            for (int v = 0; v < 8; v++) tbl[v] = 10'($urandom);
            if ($urandom_range(0, 1) == 0) sweep(model(8), (r % 3 == 0) ? int'($urandom_range(0, 23)) : -1, -1, -1);
            else sweep(model(8) ^ (10'd1 << $urandom_range(0, 9)), -1, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
